// File: rtl/video_pattern_src.sv
// Avalon-ST Video test-pattern source: one control packet followed by one
// video packet per frame, one 24-bit {B,G,R} pixel per beat, ready latency 0.
module video_pattern_src #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int CHECK_LOG2 = 5
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] dout_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic [7:0]  frame_count
);

    typedef enum logic [2:0] {
        CTRL_HDR,
        CTRL_D0,
        CTRL_D1,
        CTRL_D2,
        VID_HDR,
        VID_PIX
    } state_t;

    localparam logic [15:0] WIDTH  = 16'(H_ACTIVE);
    localparam logic [15:0] HEIGHT = 16'(V_ACTIVE);
    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] BW_LAST = 16'((H_ACTIVE >> 3) - 1);

    // Control packet payload: one nibble per symbol, symbol 0 in [7:0].
    localparam logic [23:0] CTRL_HDR_WORD = 24'h00000F;
    localparam logic [23:0] CTRL_D0_WORD  = {4'h0, WIDTH[7:4],  4'h0, WIDTH[11:8],   4'h0, WIDTH[15:12]};
    localparam logic [23:0] CTRL_D1_WORD  = {4'h0, HEIGHT[11:8], 4'h0, HEIGHT[15:12], 4'h0, WIDTH[3:0]};
    localparam logic [23:0] CTRL_D2_WORD  = {4'h0, 4'h3,        4'h0, HEIGHT[3:0],   4'h0, HEIGHT[7:4]};

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [2:0]  bar_q, bar_d;
    logic [15:0] bw_cnt_q, bw_cnt_d;
    logic [1:0]  pat_q, pat_d;
    logic [7:0]  fc_lat_q, fc_lat_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [23:0] data_q, data_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        valid_q, valid_d;
    logic        xfer;
    logic        frame_end;

    // Bar colours follow from the bar index bits: R = !b1, G = !b2, B = !b0.
    function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [15:0] x,
                                          input logic [15:0] y, input logic [2:0] bar,
                                          input logic [7:0] fc);
        logic [23:0] px;
        case (pat)
            2'd0:    px = {{8{~bar[0]}}, {8{~bar[2]}}, {8{~bar[1]}}};
            2'd1:    px = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            2'd2:    px = {x[7:0], x[7:0], x[7:0]};
            default: px = {fc, 8'h00, 8'hFF};
        endcase
        return px;
    endfunction

    assign xfer = valid_q && dout_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        bar_d       = bar_q;
        bw_cnt_d    = bw_cnt_q;
        pat_d       = pat_q;
        fc_lat_d    = fc_lat_q;
        frame_cnt_d = frame_cnt_q;
        data_d      = data_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        valid_d     = valid_q;
        frame_end   = 1'b0;

        if (!valid_q) begin
            // First cycle out of reset: present the control header.
            valid_d = 1'b1;
            data_d  = CTRL_HDR_WORD;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
        end else if (xfer) begin
            sop_d = 1'b0;
            eop_d = 1'b0;
            case (state_q)
                CTRL_HDR: begin
                    pat_d    = pattern_sel;
                    fc_lat_d = frame_cnt_q;
                    state_d  = CTRL_D0;
                    data_d   = CTRL_D0_WORD;
                end
                CTRL_D0: begin
                    state_d = CTRL_D1;
                    data_d  = CTRL_D1_WORD;
                end
                CTRL_D1: begin
                    state_d = CTRL_D2;
                    data_d  = CTRL_D2_WORD;
                    eop_d   = 1'b1;
                end
                CTRL_D2: begin
                    state_d = VID_HDR;
                    data_d  = 24'h000000;
                    sop_d   = 1'b1;
                end
                VID_HDR: begin
                    state_d  = VID_PIX;
                    x_d      = '0;
                    y_d      = '0;
                    bar_d    = '0;
                    bw_cnt_d = '0;
                end
                default: begin
                    if (x_q == X_LAST) begin
                        x_d      = '0;
                        bar_d    = '0;
                        bw_cnt_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d         = '0;
                            frame_end   = 1'b1;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                            state_d     = CTRL_HDR;
                            data_d      = CTRL_HDR_WORD;
                            sop_d       = 1'b1;
                        end else begin
                            y_d = y_q + 16'd1;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                        // Width counter steps bars; the last bar absorbs the remainder.
                        if (bar_q != 3'd7) begin
                            if (bw_cnt_q == BW_LAST) begin
                                bar_d    = bar_q + 3'd1;
                                bw_cnt_d = '0;
                            end else begin
                                bw_cnt_d = bw_cnt_q + 16'd1;
                            end
                        end
                    end
                end
            endcase

            if (state_d == VID_PIX && !frame_end) begin
                data_d = pixel(pat_q, x_d, y_d, bar_d, fc_lat_q);
                eop_d  = (x_d == X_LAST) && (y_d == Y_LAST);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q     <= CTRL_HDR;
            x_q         <= '0;
            y_q         <= '0;
            bar_q       <= '0;
            bw_cnt_q    <= '0;
            pat_q       <= '0;
            fc_lat_q    <= '0;
            frame_cnt_q <= '0;
            data_q      <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            bar_q       <= bar_d;
            bw_cnt_q    <= bw_cnt_d;
            pat_q       <= pat_d;
            fc_lat_q    <= fc_lat_d;
            frame_cnt_q <= frame_cnt_d;
            data_q      <= data_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            valid_q     <= valid_d;
        end
    end

    assign dout_data   = data_q;
    assign dout_valid  = valid_q;
    assign dout_sop    = sop_q;
    assign dout_eop    = eop_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_src.sv
// Directed bench for video_pattern_src at 16x4: packet framing, patterns,
// backpressure stability, pattern latching, mid-frame reset and counter wrap.
module tb_video_pattern_src;

    localparam int H     = 16;
    localparam int V     = 4;
    localparam int BEATS = 5 + H * V;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic [1:0]  pattern_sel;
    logic [23:0] dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_sop;
    logic        dout_eop;
    logic [7:0]  frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    video_pattern_src #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .CHECK_LOG2 (5)
    ) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .pattern_sel (pattern_sel),
        .dout_data   (dout_data),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_sop    (dout_sop),
        .dout_eop    (dout_eop),
        .frame_count (frame_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected pixel {B,G,R}; bars use a plain division, unlike the DUT.
    function automatic logic [23:0] exp_pixel(input int x, input int y, input int pat, input int fc);
        int bar;
        logic [7:0] g;
        case (pat)
            0: begin
                bar = x / (H / 8);
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 24'hFFFFFF;  // white
                    1: return 24'h00FFFF;  // yellow
                    2: return 24'hFFFF00;  // cyan
                    3: return 24'h00FF00;  // green
                    4: return 24'hFF00FF;  // magenta
                    5: return 24'h0000FF;  // red
                    6: return 24'hFF0000;  // blue
                    default: return 24'h000000;
                endcase
            end
            1: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2: begin
                g = 8'(x);
                return {g, g, g};
            end
            default: return {8'(fc), 8'h00, 8'hFF};
        endcase
    endfunction

    // Expected {eop, sop, data} for beat i of a frame.
    function automatic logic [25:0] exp_beat(input int i, input int pat, input int fc);
        int p;
        case (i)
            0: return {1'b0, 1'b1, 24'h00000F};
            1: return {1'b0, 1'b0, 24'h010000};
            2: return {1'b0, 1'b0, 24'h000000};
            3: return {1'b1, 1'b0, 24'h030400};
            4: return {1'b0, 1'b1, 24'h000000};
            default: begin
                p = i - 5;
                return {(p == H * V - 1), 1'b0, exp_pixel(p % H, p / H, pat, fc)};
            end
        endcase
    endfunction

    // Receive one frame from the current beat on; optional pattern change at
    // beat chg_at and early return (no transfer) at beat abort_at.
    task automatic recv_frame(input logic [1:0] sel, input int fc, input bit rnd,
                              input int chg_at, input logic [1:0] chg_sel, input int abort_at);
        int          idx = 0;
        int          cycles = 0;
        bit          stall = 1'b0;
        logic [25:0] cur;
        logic [25:0] held = '0;
        pattern_sel = sel;
        while (idx < BEATS && cycles < 2000) begin
            if (idx == abort_at) break;
            if (idx == chg_at) pattern_sel = chg_sel;
            cur = {dout_eop, dout_sop, dout_data};
            check($sformatf("valid_f%0d", fc), 32'(dout_valid), 32'd1);
            if (stall) check($sformatf("stall_hold_f%0d_b%0d", fc, idx), 32'(cur), 32'(held));
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dout_ready) begin
                check($sformatf("beat_f%0d_b%0d", fc, idx), 32'(cur), 32'(exp_beat(idx, sel, fc)));
                idx++;
                stall = 1'b0;
            end else begin
                stall = 1'b1;
                held  = cur;
            end
            @(posedge clk_in);
            #1;
            cycles++;
        end
        if (abort_at < 0) begin
            check($sformatf("beat_count_f%0d", fc), 32'(idx), 32'(BEATS));
            check($sformatf("frame_count_f%0d", fc), 32'(frame_count), 32'((fc + 1) % 256));
            if (!rnd) check($sformatf("throughput_f%0d", fc), 32'(cycles), 32'(BEATS));
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        dout_ready  = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) begin
            @(posedge clk_in);
            #1;
            check("reset_outputs", 32'({dout_valid, dout_sop, dout_eop, dout_data}), 32'd0);
            check("reset_frame_count", 32'(frame_count), 32'd0);
        end
        reset_n    = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk_in);
        #1;
        check("first_hdr", 32'({dout_valid, dout_sop, dout_eop, dout_data}),
              32'({1'b1, 1'b1, 1'b0, 24'h00000F}));

        // Bars; pattern_sel goes to 3 at pixel 20 and must not affect this frame.
        recv_frame(2'd0, 0, 1'b0, 25, 2'd3, -1);
        recv_frame(2'd3, 1, 1'b0, -1, 2'd0, -1);

        // Random backpressure over three frames.
        recv_frame(2'd2, 2, 1'b1, -1, 2'd0, -1);
        recv_frame(2'd1, 3, 1'b1, -1, 2'd0, -1);
        recv_frame(2'd0, 4, 1'b1, -1, 2'd0, -1);

        // One-cycle reset at pixel 30.
        recv_frame(2'd0, 5, 1'b0, -1, 2'd0, 35);
        reset_n = 1'b0;
        @(posedge clk_in);
        #1;
        check("midreset_outputs", 32'({dout_valid, dout_sop, dout_eop, dout_data}), 32'd0);
        reset_n = 1'b1;
        @(posedge clk_in);
        #1;
        check("midreset_hdr", 32'({dout_valid, dout_sop, dout_eop, dout_data}),
              32'({1'b1, 1'b1, 1'b0, 24'h00000F}));
        check("midreset_frame_count", 32'(frame_count), 32'd0);

        // 256 frames of pattern 3: counter wraps, next frame's blue is 00.
        for (int f = 0; f < 256; f++) recv_frame(2'd3, f, 1'b0, -1, 2'd0, -1);
        check("fc_wrap", 32'(frame_count), 32'd0);
        recv_frame(2'd3, 0, 1'b0, -1, 2'd0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
